bmf_factor_decoder: RTL and testbench

//  Streaming decoder for Boolean-matrix-factorised (BMF) approximate logic.

---
 rtl/bmf_factor_decoder.sv | 121 ++++++++++++
 tb/tb_bmf_factor_decoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmf_factor_decoder.sv
// Streaming BMF decoder: expands a K-bit factor vector through a runtime-loaded
// KxM basis matrix H into an M-bit output, reducing columns with OR or XOR.
module bmf_factor_decoder #(
  parameter int K        = 5,
  parameter int M        = 6,
  parameter int SEMIRING = 0,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [($clog2(K)|1)-1:0]  cfg_row,
  input  logic [M-1:0]              cfg_data,
  output logic                      cfg_ready,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [K-1:0]              s_k,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [M-1:0]              m_out,
  output logic [CNT_W-1:0]          xfer_cnt
);

  logic [M-1:0]     h_q [K];
  logic [M-1:0]     p_q [K];
  logic [M-1:0]     p_d [K];
  logic             s1_v_q;
  logic             s2_v_q;
  logic [M-1:0]     m_out_q;
  logic [M-1:0]     red_d;
  logic [CNT_W-1:0] cnt_q;

  logic s2_adv;
  logic s1_adv;
  logic s_acc;
  logic cfg_acc;
  logic xfer;

  // Config takes priority over data, and is only accepted with the pipe empty,
  // so H is constant for every vector in flight.
  always_comb begin
    s2_adv  = !s2_v_q || m_ready;
    s1_adv  = !s1_v_q || s2_adv;
    s_acc   = s_valid && !cfg_we && s1_adv;
    cfg_acc = cfg_we && !s1_v_q && !s2_v_q;
    xfer    = s2_v_q && m_ready;
  end

  always_comb begin
    for (int unsigned i = 0; i < K; i++) begin
      p_d[i] = s_k[i] ? h_q[i] : '0;
    end
  end

  always_comb begin
    red_d = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (SEMIRING == 1) begin
        red_d = red_d ^ p_q[i];
      end else begin
        red_d = red_d | p_q[i];
      end
    end
  end

  // Out-of-range rows match no index and are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < K; i++) begin
        h_q[i] <= '0;
      end
    end else if (cfg_acc) begin
      for (int unsigned i = 0; i < K; i++) begin
        if (32'(cfg_row) == i) begin
          h_q[i] <= cfg_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      for (int unsigned i = 0; i < K; i++) begin
        p_q[i] <= '0;
      end
    end else if (s1_adv) begin
      s1_v_q <= s_acc;
      if (s_acc) begin
        p_q <= p_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q  <= 1'b0;
      m_out_q <= '0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        m_out_q <= red_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cfg_ready = !s1_v_q && !s2_v_q;
  assign s_ready   = !cfg_we && s1_adv;
  assign m_valid   = s2_v_q;
  assign m_out     = m_out_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_bmf_factor_decoder.sv
// Bench for bmf_factor_decoder: an OR-semiring and an XOR-semiring instance
// share stimulus and are checked against a FIFO-level reference model.
module tb_bmf_factor_decoder;

  localparam int K = 5;
  localparam int M = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [2:0]   cfg_row;
  logic [M-1:0] cfg_data;
  logic         s_valid;
  logic [K-1:0] s_k;
  logic         m_ready;

  logic         or_cfg_ready, or_s_ready, or_m_valid;
  logic [M-1:0] or_m_out;
  logic [3:0]   or_cnt;
  logic         xr_cfg_ready, xr_s_ready, xr_m_valid;
  logic [M-1:0] xr_m_out;
  logic [15:0]  xr_cnt;

  always #5 clk = ~clk;

  bmf_factor_decoder #(.K(K), .M(M), .SEMIRING(0), .CNT_W(4)) u_or (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_row(cfg_row),
    .cfg_data(cfg_data), .cfg_ready(or_cfg_ready), .s_valid(s_valid),
    .s_ready(or_s_ready), .s_k(s_k), .m_valid(or_m_valid),
    .m_ready(m_ready), .m_out(or_m_out), .xfer_cnt(or_cnt)
  );

  bmf_factor_decoder #(.K(K), .M(M), .SEMIRING(1), .CNT_W(16)) u_xr (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_row(cfg_row),
    .cfg_data(cfg_data), .cfg_ready(xr_cfg_ready), .s_valid(s_valid),
    .s_ready(xr_s_ready), .s_k(s_k), .m_valid(xr_m_valid),
    .m_ready(m_ready), .m_out(xr_m_out), .xfer_cnt(xr_cnt)
  );

  typedef struct {
    int           age;
    logic [M-1:0] v_or;
    logic [M-1:0] v_xr;
  } ent_t;

  typedef struct {
    logic [2:0]   row;
    logic [M-1:0] data;
  } cfg_t;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [M-1:0] hm [K];
  ent_t         pipe [$];
  logic [K-1:0] src [$];
  cfg_t         cfgq [$];
  logic [M-1:0] last_or, last_xr;
  int unsigned  cnt_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic void model_out(input logic [K-1:0] k, output logic [M-1:0] o, output logic [M-1:0] x);
    for (int j = 0; j < M; j++) begin
      int n = 0;
      for (int i = 0; i < K; i++) if (k[i] && hm[i][j]) n++;
      o[j] = (n > 0);
      x[j] = (n % 2 == 1);
    end
  endfunction

  task automatic model_clear();
    pipe.delete(); src.delete(); cfgq.delete();
    for (int i = 0; i < K; i++) hm[i] = '0;
    last_or = '0; last_xr = '0; cnt_model = 0;
  endtask

  task automatic step();
    bit vis, pop, exp_sr, exp_cr, acc_s, acc_c;
    s_valid = (src.size() > 0);
    s_k     = s_valid ? src[0] : 5'($urandom);
    cfg_we  = (cfgq.size() > 0);
    if (cfg_we) begin
      cfg_row  = cfgq[0].row;
      cfg_data = cfgq[0].data;
    end
    @(negedge clk);
    vis    = (pipe.size() > 0) && (pipe[0].age >= 1);
    pop    = vis && m_ready;
    exp_sr = !cfg_we && ((pipe.size() - int'(pop)) < 2);
    exp_cr = (pipe.size() == 0);
    if (vis) begin
      last_or = pipe[0].v_or;
      last_xr = pipe[0].v_xr;
    end
    chk("or_m_valid", 32'(or_m_valid), 32'(vis));
    chk("xr_m_valid", 32'(xr_m_valid), 32'(vis));
    chk("or_m_out", 32'(or_m_out), 32'(last_or));
    chk("xr_m_out", 32'(xr_m_out), 32'(last_xr));
    chk("or_s_ready", 32'(or_s_ready), 32'(exp_sr));
    chk("xr_s_ready", 32'(xr_s_ready), 32'(exp_sr));
    chk("or_cfg_ready", 32'(or_cfg_ready), 32'(exp_cr));
    chk("xr_cfg_ready", 32'(xr_cfg_ready), 32'(exp_cr));
    chk("or_xfer_cnt", 32'(or_cnt), cnt_model % 16);
    chk("xr_xfer_cnt", 32'(xr_cnt), cnt_model % 65536);
    acc_s = s_valid && exp_sr;
    acc_c = cfg_we && exp_cr;
    @(posedge clk);
    if (rst_n) begin
      foreach (pipe[i]) pipe[i].age++;
      if (pop) begin
        void'(pipe.pop_front());
        cnt_model++;
      end
      if (acc_s) begin
        ent_t e;
        e.age = 0;
        model_out(src[0], e.v_or, e.v_xr);
        pipe.push_back(e);
        void'(src.pop_front());
      end
      if (acc_c) begin
        if (cfgq[0].row < K) hm[cfgq[0].row] = cfgq[0].data;
        void'(cfgq.pop_front());
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int n = 0;
    while ((src.size() > 0 || cfgq.size() > 0 || pipe.size() > 0) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_err++;
      $error("FAIL drain_timeout observed=%0d cycles expected=<200", n);
    end
  endtask

  task automatic wr(input logic [2:0] row, input logic [M-1:0] data);
    cfg_t c;
    c.row = row;
    c.data = data;
    cfgq.push_back(c);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_or_m_valid", 32'(or_m_valid), 0);
    chk("rst_xr_m_valid", 32'(xr_m_valid), 0);
    chk("rst_or_cnt", 32'(or_cnt), 0);
    chk("rst_xr_cnt", 32'(xr_cnt), 0);
    chk("rst_or_m_out", 32'(or_m_out), 0);
    chk("rst_cfg_ready", 32'(or_cfg_ready), 1);
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; cfg_we = 1'b0; cfg_row = '0; cfg_data = '0;
    s_valid = 1'b0; s_k = '0; m_ready = 1'b1;
    model_clear();
    #2;
    reset_now();

    // Test 1: basis load and two directed vectors
    wr(3'd0, 6'b000010); wr(3'd1, 6'b000101); wr(3'd2, 6'b001000);
    wr(3'd3, 6'b010000); wr(3'd4, 6'b100000);
    drain();
    src.push_back(5'b00010);
    run(2);
    chk("t1_valid", 32'(or_m_valid), 1);
    chk("t1_or_out", 32'(or_m_out), 32'h05);
    chk("t1_xr_out", 32'(xr_m_out), 32'h05);
    src.push_back(5'b11111);
    run(2);
    chk("t1b_or_out", 32'(or_m_out), 32'h3f);
    chk("t1b_xr_out", 32'(xr_m_out), 32'h3f);
    drain();

    // Test 2: eight back-to-back vectors
    for (int i = 0; i < 8; i++) src.push_back(5'($urandom));
    drain();
    chk("t2_or_cnt", 32'(or_cnt), 10);
    chk("t2_xr_cnt", 32'(xr_cnt), 10);

    // Test 3: output stall with three vectors offered
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) src.push_back(5'($urandom));
    run(5);
    chk("t3_s_ready", 32'(or_s_ready), 0);
    chk("t3_m_valid", 32'(or_m_valid), 1);
    chk("t3_pending", 32'(src.size()), 1);
    m_ready = 1'b1;
    drain();
    chk("t3_cnt", 32'(xr_cnt), 13);

    // Test 4: config request while a vector is in flight
    src.push_back(5'b00101);
    step();
    wr(3'd2, 6'b111000);
    src.push_back(5'b00001);
    step();
    chk("t4_cfg_ready", 32'(or_cfg_ready), 0);
    chk("t4_s_ready", 32'(or_s_ready), 0);
    drain();
    src.push_back(5'b00100);
    run(2);
    chk("t4_new_row", 32'(or_m_out), 32'h38);

    // Test 5: OR vs XOR reduction, plus out-of-range rows ignored
    wr(3'd0, 6'b000011); wr(3'd1, 6'b000001); wr(3'd2, 6'b000000);
    wr(3'd3, 6'b000000); wr(3'd4, 6'b000000);
    wr(3'd5, 6'b111111); wr(3'd7, 6'b101010);
    drain();
    src.push_back(5'b00011);
    run(2);
    chk("t5_or_out", 32'(or_m_out), 32'h03);
    chk("t5_xr_out", 32'(xr_m_out), 32'h02);
    src.push_back(5'b11111);
    run(2);
    chk("t5_oor_or", 32'(or_m_out), 32'h03);
    drain();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if (src.size() < 3 && $urandom_range(0, 3) != 0) src.push_back(5'($urandom));
      if (cfgq.size() == 0 && $urandom_range(0, 19) == 0)
        wr(3'($urandom_range(0, 7)), 6'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    m_ready = 1'b1;
    drain();

    // Test 6: reset mid-stream, then counter wrap
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) src.push_back(5'($urandom));
    run(3);
    reset_now();
    m_ready = 1'b1;
    src.push_back(5'b11111);
    run(2);
    chk("t6_valid", 32'(or_m_valid), 1);
    chk("t6_zero_or", 32'(or_m_out), 0);
    chk("t6_zero_xr", 32'(xr_m_out), 0);
    drain();
    for (int i = 0; i < 15; i++) src.push_back(5'($urandom));
    drain();
    chk("t6_wrap_or", 32'(or_cnt), 0);
    chk("t6_wide_xr", 32'(xr_cnt), 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
